// File: rtl/extmem_arbiter.sv
`default_nettype none

`ifndef ADDR_EXT_RAM
`define ADDR_EXT_RAM 24
`endif
`ifndef DATA_EXT_RAM
`define DATA_EXT_RAM 32
`endif

// ============================================================================
// Module   : extmem_arbiter
// Brief    : Round-robin burst arbiter sharing one external memory port
//            between NUM_REQ requesters. One word per cycle; read data is
//            returned aligned to the memory's 1-cycle registered read.
// Revision : 1.0 - initial release
// ============================================================================
module extmem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = `ADDR_EXT_RAM,
    parameter int DATA_W  = `DATA_EXT_RAM,
    parameter int LEN_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ-1:0]        wvalid,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        wr_rdy,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        done,
    output logic                      mem_re,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_wr_addr,
    output logic [DATA_W-1:0]         mem_wr_data
);

    localparam int               c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_IDX_W:0] c_NUM   = (c_IDX_W + 1)'(NUM_REQ);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BURST = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_we_mode;
    logic [ADDR_W-1:0]  r_base;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic               r_re_q;

    logic               w_found;
    logic [c_IDX_W-1:0] w_win;
    logic [c_IDX_W:0]   w_idx;
    logic [NUM_REQ-1:0] w_win_oh;
    logic               w_win_we;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [LEN_W-1:0]   w_win_len;
    logic [DATA_W-1:0]  w_wdata_sel;
    logic               w_wvalid_sel;
    logic               w_beat;
    logic               w_last;
    logic [ADDR_W-1:0]  w_addr;

    // Round-robin search: first active request after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(k);
            if (w_idx >= c_NUM) begin
                w_idx = w_idx - c_NUM;
            end
            if (!w_found && req[w_idx[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_IDX_W-1:0];
            end
        end
    end

    // Slice muxes: winner's burst descriptor and granted requester's write word.
    always_comb begin
        w_win_oh     = '0;
        w_win_we     = 1'b0;
        w_win_addr   = '0;
        w_win_len    = '0;
        w_wdata_sel  = '0;
        w_wvalid_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == c_IDX_W'(i)) begin
                w_win_oh[i] = 1'b1;
                w_win_we    = req_we[i];
                w_win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_win_len   = req_len[i*LEN_W +: LEN_W];
            end
            if (r_gnt[i]) begin
                w_wdata_sel  = w_wdata_sel | wdata[i*DATA_W +: DATA_W];
                w_wvalid_sel = w_wvalid_sel | wvalid[i];
            end
        end
    end

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and memory strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        w_beat      = 1'b0;
        w_last      = (r_cnt == (r_len - LEN_W'(1)));
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_nxt = (w_win_len == '0) ? c_DONE : c_BURST;
                end
            end
            c_BURST: begin
                if (r_we_mode) begin
                    mem_we = w_wvalid_sel;
                    w_beat = w_wvalid_sel;
                    if (w_beat && w_last) begin
                        w_state_nxt = c_DONE;
                    end
                end else begin
                    mem_re = 1'b1;
                    w_beat = 1'b1;
                    if (w_last) begin
                        w_state_nxt = c_DRAIN;
                    end
                end
            end
            c_DRAIN: w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Burst descriptor capture, beat counter, grant and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt     <= '0;
            r_we_mode <= 1'b0;
            r_base    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_rr_ptr  <= c_IDX_W'(NUM_REQ - 1);
            r_re_q    <= 1'b0;
        end else begin
            r_re_q <= mem_re;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_gnt     <= w_win_oh;
                        r_we_mode <= w_win_we;
                        r_base    <= w_win_addr;
                        r_len     <= w_win_len;
                        r_cnt     <= '0;
                        r_rr_ptr  <= w_win;
                    end
                end
                c_BURST: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                    end
                end
                c_DONE:  r_gnt <= '0;
                default: ;
            endcase
        end
    end

    assign w_addr      = r_base + ADDR_W'(r_cnt);
    assign gnt         = r_gnt;
    assign wr_rdy      = mem_we ? r_gnt : '0;
    assign rd_valid    = r_re_q ? r_gnt : '0;
    assign rd_data     = mem_rd_data;
    assign done        = (r_state == c_DONE) ? r_gnt : '0;
    assign mem_rd_addr = w_addr;
    assign mem_wr_addr = w_addr;
    assign mem_wr_data = w_wdata_sel;

endmodule

`default_nettype wire

// File: tb/tb_extmem_arbiter.sv
`default_nettype none

// ============================================================================
// Module   : tb_extmem_arbiter
// Brief    : Directed self-checking bench for extmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_extmem_arbiter;

    localparam int NR = 3;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int LW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req, req_we, wvalid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_len;
    logic [NR*DW-1:0]  wdata;
    logic [NR-1:0]     gnt, wr_rdy, rd_valid, done;
    logic [DW-1:0]     rd_data;
    logic              mem_re, mem_we;
    logic [AW-1:0]     mem_rd_addr, mem_wr_addr;
    logic [DW-1:0]     mem_rd_data, mem_wr_data;

    int n_vec = 0;
    int n_err = 0;

    extmem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_len(req_len), .wvalid(wvalid), .wdata(wdata), .gnt(gnt), .wr_rdy(wr_rdy),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .mem_re(mem_re),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_we(mem_we),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    // Memory contents: 0x100..0x103 hold 1..4, everything else a tagged address.
    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        if (a >= 24'h000100 && a <= 24'h000103) return 32'(a - 24'h0000FF);
        return {8'hA5, a};
    endfunction

    // Registered read port, one cycle latency.
    always @(posedge clk) begin
        if (mem_re) mem_rd_data <= memval(mem_rd_addr);
    end

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_we[i]         = we;
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]  = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_we = '0; wvalid = '0;
        req_addr = '0; req_len = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({gnt, done, rd_valid, wr_rdy, mem_re, mem_we} !== 14'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b", {gnt, done, rd_valid, wr_rdy, mem_re, mem_we}, 14'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_burst();
        int nre = 0, nrv = 0, ndone = 0, t_done = -1, t_gnt = -1;
        logic [AW-1:0] ea;
        set_req(0, 1'b0, 24'h000100, 16'd4);
        req[0] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (gnt[0] && t_gnt < 0) t_gnt = c;
            if (mem_re) begin
                ea = 24'h000100 + AW'(nre);
                n_vec++;
                if (mem_rd_addr !== ea) begin
                    n_err++;
                    $display("FAIL rd_burst_addr: got %h expected %h", mem_rd_addr, ea);
                end
                nre++;
            end
            if (rd_valid[0]) begin
                n_vec++;
                if (rd_data !== DW'(nrv + 1)) begin
                    n_err++;
                    $display("FAIL rd_burst_data: got %h expected %h", rd_data, DW'(nrv + 1));
                end
                nrv++;
            end
            if (done[0]) begin ndone++; t_done = c; req[0] = 1'b0; end
            @(posedge clk); #1;
        end
        n_vec++;
        if ({nre, nrv, ndone, t_gnt, t_done} !== {32'd4, 32'd4, 32'd1, 32'd1, 32'd6}) begin
            n_err++;
            $display("FAIL rd_burst_counts: got re=%0d rv=%0d done=%0d tgnt=%0d tdone=%0d expected 4 4 1 1 6",
                     nre, nrv, ndone, t_gnt, t_done);
        end
    endtask

    task automatic test_write_burst();
        logic [DW-1:0] wd [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        logic [3:0]    pat = 4'b1101;
        int nb = 0, ndone = 0, t_done = -1;
        set_req(1, 1'b1, 24'h1E0000, 16'd3);
        req[1] = 1'b1;
        wvalid[0] = 1'b1; wdata[0 +: DW] = 32'hDEAD_0000;
        for (int c = 0; c < 12; c++) begin
            wvalid[1] = 1'b0; wdata[DW +: DW] = '0;
            if (c >= 1 && c <= 4 && pat[c-1] && nb < 3) begin
                wvalid[1] = 1'b1; wdata[DW +: DW] = wd[nb];
            end
            #1;
            n_vec++;
            if (((wr_rdy & ~gnt) !== 3'b000) || (mem_re !== 1'b0)) begin
                n_err++;
                $display("FAIL wr_isolation: got wr_rdy=%b gnt=%b re=%b expected no stray strobes", wr_rdy, gnt, mem_re);
            end
            if (c == 2) begin
                n_vec++;
                if (mem_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL wr_stall: got mem_we=%b expected 0", mem_we);
                end
            end
            if (mem_we && nb < 3) begin
                n_vec++;
                if (mem_wr_addr !== 24'h1E0000 + AW'(nb) || mem_wr_data !== wd[nb] || wr_rdy !== 3'b010) begin
                    n_err++;
                    $display("FAIL wr_beat: got %h/%h/%b expected %h/%h/010", mem_wr_addr, mem_wr_data, wr_rdy,
                             24'h1E0000 + AW'(nb), wd[nb]);
                end
                nb++;
            end
            if (done[1]) begin ndone++; t_done = c; req[1] = 1'b0; end
            @(posedge clk); #1;
        end
        wvalid = '0;
        n_vec++;
        if ({nb, ndone, t_done} !== {32'd3, 32'd1, 32'd5}) begin
            n_err++;
            $display("FAIL wr_counts: got beats=%0d done=%0d tdone=%0d expected 3 1 5", nb, ndone, t_done);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] order [6];
        logic [NR-1:0] exp_o [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        logic [NR-1:0] prev = '0;
        logic raised = 1'b0;
        int n = 0;
        rst_n = 1'b0;
        set_req(0, 1'b0, 24'h000200, 16'd2);
        set_req(1, 1'b0, 24'h000300, 16'd2);
        set_req(2, 1'b0, 24'h000400, 16'd2);
        req = 3'b111;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (gnt !== 3'b000 && gnt !== prev && n < 6) begin order[n] = gnt; n++; end
            prev = gnt;
            n_vec++;
            if ($countones(gnt) > 1) begin
                n_err++;
                $display("FAIL rr_onehot: got gnt=%b expected at most one bit", gnt);
            end
            if (gnt == 3'b100 && !raised) begin req[0] = 1'b1; req[1] = 1'b1; raised = 1'b1; end
            for (int i = 0; i < NR; i++) if (done[i]) req[i] = 1'b0;
            @(posedge clk); #1;
        end
        n_vec++;
        if (n !== 5) begin
            n_err++;
            $display("FAIL rr_grant_count: got %0d expected 5", n);
        end
        for (int i = 0; i < 5 && i < n; i++) begin
            n_vec++;
            if (order[i] !== exp_o[i]) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got %b expected %b", i, order[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int nre = 0, nrv = 0, ndone = 0, t_done = -1;
        logic [AW-1:0] ea, da;
        set_req(2, 1'b0, 24'hFFFFFE, 16'd4);
        req[2] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (mem_re) begin
                ea = 24'hFFFFFE + AW'(nre);
                n_vec++;
                if (mem_rd_addr !== ea) begin
                    n_err++;
                    $display("FAIL wrap_addr: got %h expected %h", mem_rd_addr, ea);
                end
                nre++;
            end
            if (rd_valid !== 3'b000) begin
                da = 24'hFFFFFE + AW'(nrv);
                n_vec++;
                if (rd_valid !== 3'b100 || rd_data !== memval(da)) begin
                    n_err++;
                    $display("FAIL wrap_data: got %b/%h expected 100/%h", rd_valid, rd_data, memval(da));
                end
                nrv++;
            end
            if (c == 7) begin
                n_vec++;
                if (gnt !== 3'b000) begin
                    n_err++;
                    $display("FAIL wrap_release: got gnt=%b expected 000", gnt);
                end
            end
            if (done[2]) begin ndone++; t_done = c; req[2] = 1'b0; end
            @(posedge clk); #1;
        end
        n_vec++;
        if ({nre, nrv, ndone, t_done} !== {32'd4, 32'd4, 32'd1, 32'd6}) begin
            n_err++;
            $display("FAIL wrap_counts: got re=%0d rv=%0d done=%0d tdone=%0d expected 4 4 1 6", nre, nrv, ndone, t_done);
        end
    endtask

    task automatic test_zero_len();
        int ng = 0, t_done = -1, nstrobe = 0;
        set_req(0, 1'b0, 24'h000500, 16'd0);
        req[0] = 1'b1;
        wvalid = 3'b001;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (gnt[0]) ng++;
            if (mem_re || mem_we) nstrobe++;
            if (done[0]) begin t_done = c; req[0] = 1'b0; end
            @(posedge clk); #1;
        end
        wvalid = '0;
        n_vec++;
        if ({ng, t_done, nstrobe} !== {32'd1, 32'd1, 32'd0}) begin
            n_err++;
            $display("FAIL zero_len: got gnt_cycles=%0d tdone=%0d strobes=%0d expected 1 1 0", ng, t_done, nstrobe);
        end
    endtask

    task automatic test_reset_mid_burst();
        int ndone = 0, nrv = 0, t_gnt = -1, t_done = -1;
        set_req(0, 1'b0, 24'h000100, 16'd8);
        req[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) begin rst_n = 1'b0; req[0] = 1'b0; end
            if (c == 4) rst_n = 1'b1;
            #1;
            if (c == 3) begin
                n_vec++;
                if (mem_re !== 1'b1 || gnt !== 3'b001) begin
                    n_err++;
                    $display("FAIL abort_pre: got re=%b gnt=%b expected 1/001", mem_re, gnt);
                end
            end
            if (c == 4) begin
                n_vec++;
                if ({gnt, done, rd_valid, wr_rdy, mem_re, mem_we} !== 14'b0) begin
                    n_err++;
                    $display("FAIL abort_outputs: got %b expected %b", {gnt, done, rd_valid, wr_rdy, mem_re, mem_we}, 14'b0);
                end
            end
            if (done !== 3'b000) ndone++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (ndone !== 0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d done cycles expected 0", ndone);
        end
        set_req(0, 1'b0, 24'h000100, 16'd2);
        req[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (gnt[0] && t_gnt < 0) t_gnt = c;
            if (rd_valid[0]) begin
                n_vec++;
                if (rd_data !== DW'(nrv + 1)) begin
                    n_err++;
                    $display("FAIL regrant_data: got %h expected %h", rd_data, DW'(nrv + 1));
                end
                nrv++;
            end
            if (done[0]) begin t_done = c; req[0] = 1'b0; end
            @(posedge clk); #1;
        end
        n_vec++;
        if ({t_gnt, nrv, t_done} !== {32'd1, 32'd2, 32'd4}) begin
            n_err++;
            $display("FAIL regrant: got tgnt=%0d rv=%0d tdone=%0d expected 1 2 4", t_gnt, nrv, t_done);
        end
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_burst();
        test_round_robin();
        test_wrap();
        test_zero_len();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
